// File: rtl/ps2_host_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// ps2_host_transmitter_pkg : state encodings, keyboard command codes, defaults
// Rev 1.0
// ============================================================================
package ps2_host_transmitter_pkg;

    localparam logic [2:0] PS2TX_IDLE    = 3'd0;
    localparam logic [2:0] PS2TX_INHIBIT = 3'd1;
    localparam logic [2:0] PS2TX_REQ     = 3'd2;
    localparam logic [2:0] PS2TX_SHIFT   = 3'd3;
    localparam logic [2:0] PS2TX_ACK     = 3'd4;
    localparam logic [2:0] PS2TX_RECOVER = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    localparam int PS2TX_DEF_INHIBIT_CYCLES = 2500;
    localparam int PS2TX_DEF_TIMEOUT_CYCLES = 375000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// ps2_line_sync : 2-FF synchronizers for PS/2 clock and data plus clock-fall detect
// Rev 1.0
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic ps2_clk_o,
    output logic ps2_data_o,
    output logic fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;

    // Idle bus level is high, so resetting to 1 avoids a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign ps2_clk_o  = clk_sync_q[1];
    assign ps2_data_o = data_sync_q[1];
    assign fall_o     = clk_prev_q & ~clk_sync_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_transmitter.sv
`default_nettype none
// ============================================================================
// ps2_host_transmitter : PS/2 host-to-device command sender, open-drain pull-low
// enables. Optional device-clock watchdog: define PS2_TX_WATCHDOG_EN.  Rev 1.0
// ============================================================================
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2TX_DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2TX_DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       oPS2_CLK_LOW,
    output logic       oPS2_DATA_LOW,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckError,
    output logic       oTimeout
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic          ps2_clk_s;
    logic          ps2_data_s;
    logic          dev_fall;

    logic [2:0]    state_q,    state_d;
    logic [9:0]    shift_q,    shift_d;
    logic [3:0]    bitcnt_q,   bitcnt_d;
    logic [CW-1:0] cyc_q,      cyc_d;
    logic          clk_low_q,  clk_low_d;
    logic          data_low_q, data_low_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          ack_err_q,  ack_err_d;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (PS2_CLK),
        .ps2_data_i (PS2_DATA),
        .ps2_clk_o  (ps2_clk_s),
        .ps2_data_o (ps2_data_s),
        .fall_o     (dev_fall)
    );

`ifdef PS2_TX_WATCHDOG_EN
    logic timeout_q, timeout_d;
    logic wd_expired;

    assign wd_expired = (cyc_q == CW'(TIMEOUT_CYCLES - 1));
    assign oTimeout   = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end
`else
    assign oTimeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        cyc_d      = cyc_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
`ifdef PS2_TX_WATCHDOG_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            PS2TX_IDLE: begin
                if (iStart) begin
                    shift_d    = {1'b1, odd_parity(iData), iData};
                    bitcnt_d   = '0;
                    cyc_d      = '0;
                    ack_err_d  = 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
                    timeout_d  = 1'b0;
`endif
                    clk_low_d  = 1'b1;
                    data_low_d = (INHIBIT_CYCLES <= 1);
                    busy_d     = 1'b1;
                    state_d    = PS2TX_INHIBIT;
                end
            end
            PS2TX_INHIBIT: begin
                cyc_d = cyc_q + 1'b1;
                // Start bit goes out during the last inhibit cycle
                if (cyc_q == CW'(INHIBIT_CYCLES - 2)) data_low_d = 1'b1;
                if (cyc_q == CW'(INHIBIT_CYCLES - 1)) begin
                    clk_low_d = 1'b0;
                    cyc_d     = '0;
                    state_d   = PS2TX_REQ;
                end
            end
            PS2TX_REQ, PS2TX_SHIFT: begin
                // First device fall in REQ already carries data bit 0
                if (dev_fall) begin
                    data_low_d = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    bitcnt_d   = bitcnt_q + 1'b1;
                    state_d    = (bitcnt_q == 4'd9) ? PS2TX_ACK : PS2TX_SHIFT;
                end
            end
            PS2TX_ACK: begin
                if (dev_fall) begin
                    ack_err_d = ps2_data_s;
                    state_d   = PS2TX_RECOVER;
                end
            end
            PS2TX_RECOVER: begin
                if (ps2_clk_s && ps2_data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = PS2TX_IDLE;
                end
            end
            default: state_d = PS2TX_IDLE;
        endcase
`ifdef PS2_TX_WATCHDOG_EN
        if (state_q == PS2TX_REQ || state_q == PS2TX_SHIFT || state_q == PS2TX_ACK) begin
            cyc_d = dev_fall ? '0 : cyc_q + 1'b1;
            if (wd_expired) begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                timeout_d  = 1'b1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                cyc_d      = '0;
                state_d    = PS2TX_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PS2TX_IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            cyc_q      <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            cyc_q      <= cyc_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign oPS2_CLK_LOW  = clk_low_q;
    assign oPS2_DATA_LOW = data_low_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oAckError     = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_transmitter.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_transmitter : device-model bench for the PS/2 host transmitter
// Rev 1.0
// ============================================================================
module tb_ps2_host_transmitter;

    localparam int INH  = 2500;
    localparam int HALF = 20;
`ifdef PS2_TX_WATCHDOG_EN
    localparam int TO = 3000;
`else
    localparam int TO = 375000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;
    logic       oPS2_CLK_LOW, oPS2_DATA_LOW, oBusy, oDone, oAckError, oTimeout;

    // Wired-AND of the open-drain bus: either side may pull low
    assign ps2_clk_line  = dev_clk  & ~oPS2_CLK_LOW;
    assign ps2_data_line = dev_data & ~oPS2_DATA_LOW;

    ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iStart        (iStart),
        .iData         (iData),
        .PS2_CLK       (ps2_clk_line),
        .PS2_DATA      (ps2_data_line),
        .oPS2_CLK_LOW  (oPS2_CLK_LOW),
        .oPS2_DATA_LOW (oPS2_DATA_LOW),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oAckError     (oAckError),
        .oTimeout      (oTimeout)
    );

    always #20 clk = ~clk;

    int   done_total = 0;
    int   done_with_busy = 0;
    int   clk_low_rises = 0;
    logic clk_low_prev = 1'b0;

    always @(negedge clk) begin
        if (oDone)          done_total     <= done_total + 1;
        if (oDone && oBusy) done_with_busy <= done_with_busy + 1;
        if (oPS2_CLK_LOW && !clk_low_prev) clk_low_rises <= clk_low_rises + 1;
        clk_low_prev <= oPS2_CLK_LOW;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int  ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         parity;
        bit         ack_err;
    } vec_t;

    vec_t vecs[5];

    task automatic pulse_start(input logic [7:0] d, input int hold);
        iData  = d;
        iStart = 1'b1;
        repeat (hold) @(negedge clk);
        iStart = 1'b0;
    endtask

    task automatic measure_inhibit(output bit started, output int len, output int dlow,
                                   output bit busy0, output bit ackerr0, output bit dlow_last);
        int w = 0;
        started = 0; len = 0; dlow = 0; busy0 = 0; ackerr0 = 1; dlow_last = 0;
        while (!oPS2_CLK_LOW && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!oPS2_CLK_LOW) return;
        started = 1;
        busy0   = oBusy;
        ackerr0 = oAckError;
        while (oPS2_CLK_LOW && len < 10000) begin
            len++;
            dlow_last = oPS2_DATA_LOW;
            if (oPS2_DATA_LOW) dlow++;
            @(negedge clk);
        end
    endtask

    task automatic dev_clock(output logic s);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        s = ps2_data_line;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic txn(input string tag, input logic [7:0] d, input bit ack, input int hold,
                       input bit mid, input logic [10:0] exp_frame, input bit exp_err);
        bit started, busy0, ackerr0, dlow_last;
        int len, dlow, d0, r0, db0, w;
        logic [10:0] frame;
        logic b;
        d0 = done_total; r0 = clk_low_rises; db0 = done_with_busy;
        fork
            pulse_start(d, hold);
            measure_inhibit(started, len, dlow, busy0, ackerr0, dlow_last);
        join
        check({tag, "_inhibit_start"}, 32'(started), 1);
        if (!started) return;
        check({tag, "_inhibit_len"}, len, INH);
        check({tag, "_start_bit_cycles"}, dlow, 1);
        check({tag, "_start_bit_last"}, 32'(dlow_last), 1);
        check({tag, "_busy_at_inhibit"}, 32'(busy0), 1);
        check({tag, "_ackerr_cleared"}, 32'(ackerr0), 0);
        repeat (8) @(negedge clk);
        frame[0] = ps2_data_line;
        for (int k = 1; k <= 10; k++) begin
            if (mid && k == 5) begin
                iStart = 1'b1;
                @(negedge clk);
                iStart = 1'b0;
            end
            dev_clock(b);
            frame[k] = b;
        end
        if (ack) dev_data = 1'b0;
        repeat (4) @(negedge clk);
        dev_clock(b);
        dev_data = 1'b1;
        w = 0;
        while (oBusy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_busy_release"}, 32'(oBusy), 0);
        repeat (30) @(negedge clk);
        check({tag, "_frame"}, 32'(frame), 32'(exp_frame));
        check({tag, "_done_pulses"}, done_total - d0, 1);
        check({tag, "_done_busy_overlap"}, done_with_busy - db0, 0);
        check({tag, "_transactions"}, clk_low_rises - r0, 1);
        check({tag, "_ack_error"}, 32'(oAckError), 32'(exp_err));
        check({tag, "_timeout"}, 32'(oTimeout), 0);
    endtask

    initial begin
        bit started, busy0, ackerr0, dlow_last;
        int len, dlow, d0, n;
        logic b;
        logic [7:0] rd;
        bit rack;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hEE, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_clk_low",  32'(oPS2_CLK_LOW), 0);
        check("rst_data_low", 32'(oPS2_DATA_LOW), 0);
        check("rst_busy",     32'(oBusy), 0);
        check("rst_done",     32'(oDone), 0);
        check("rst_ackerr",   32'(oAckError), 0);
        check("rst_timeout",  32'(oTimeout), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++)
            txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, 1, 1'b0,
                {1'b1, vecs[i].parity, vecs[i].data, 1'b0}, vecs[i].ack_err);

        // iStart held for 3 cycles and re-pulsed mid-frame: one transaction only
        txn("hold", 8'hEE, 1'b1, 3, 1'b1, model_frame(8'hEE), 1'b0);

        // Reset after the fifth device fall
        d0 = done_total;
        fork
            pulse_start(8'hA5, 1);
            measure_inhibit(started, len, dlow, busy0, ackerr0, dlow_last);
        join
        repeat (8) @(negedge clk);
        for (int k = 1; k <= 5; k++) dev_clock(b);
        repeat (2) @(negedge clk);
        check("midrst_pre_data_low", 32'(oPS2_DATA_LOW), 1);
        check("midrst_pre_busy",     32'(oBusy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_clk_low",  32'(oPS2_CLK_LOW), 0);
        check("midrst_data_low", 32'(oPS2_DATA_LOW), 0);
        check("midrst_busy",     32'(oBusy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_total - d0, 0);
        check("midrst_idle",    32'(oBusy), 0);

        for (int i = 0; i < 6; i++) begin
            rd   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            txn($sformatf("rnd%0d", i), rd, rack, 1, 1'b0, model_frame(rd), !rack);
        end

        // Device never clocks after the request
        d0 = done_total;
        fork
            pulse_start(8'h12, 1);
            measure_inhibit(started, len, dlow, busy0, ackerr0, dlow_last);
        join
        check("hang_inhibit_start", 32'(started), 1);
`ifdef PS2_TX_WATCHDOG_EN
        n = 0;
        while (!oDone && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check("wd_latency",  n, TO);
        check("wd_timeout",  32'(oTimeout), 1);
        check("wd_clk_low",  32'(oPS2_CLK_LOW), 0);
        check("wd_data_low", 32'(oPS2_DATA_LOW), 0);
        check("wd_busy",     32'(oBusy), 0);
        repeat (10) @(negedge clk);
        txn("after_wd", 8'hFF, 1'b1, 1, 1'b0, model_frame(8'hFF), 1'b0);
`else
        n = 0;
        repeat (3000) @(negedge clk);
        check("hang_busy",     32'(oBusy), 1);
        check("hang_clk_low",  32'(oPS2_CLK_LOW), 0);
        check("hang_data_low", 32'(oPS2_DATA_LOW), 1);
        check("hang_no_done",  done_total - d0 + n, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hang_reset_busy", 32'(oBusy), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
